// File: rtl/gray_count_source_if.sv
// Bundle of the button/switch inputs and the counter outputs of
// gray_count_source. The slave side is the counter block itself; the master
// side is whatever drives the raw board inputs and consumes the code.
interface gray_count_source_if;
    logic       button;
    logic       dir;
    logic       auto_en;
    logic [7:0] gray_out;
    logic [7:0] bin_out;
    logic       step_pulse;

    modport master (
        output button, dir, auto_en,
        input  gray_out, bin_out, step_pulse
    );

    modport slave (
        input  button, dir, auto_en,
        output gray_out, bin_out, step_pulse
    );
endinterface

// File: rtl/gray_count_source.sv
// Gray-code counter source for the four-digit LED driver.
// Raw button/dir/auto_en are synchronised, the button is debounced by a
// four-state FSM, and each accepted press (or automatic tick) steps an 8-bit
// binary counter up or down. The counter is presented Gray-encoded and
// registered, one cycle behind the binary value.
module gray_count_source #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [25:0] AUTO_PERIOD     = 26'd50000000
) (
    input  logic                clock,
    input  logic                reset,
    gray_count_source_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } db_state_t;

    logic        r_btn_s1, r_btn_s2;
    logic        r_dir_s1, r_dir_s2;
    logic        r_auto_s1, r_auto_s2;

    db_state_t   r_state, w_state_nxt;
    logic [19:0] r_db_cnt, w_db_cnt_nxt;
    logic        w_press;
    logic        r_press_evt;

    logic [25:0] r_auto_cnt;
    logic        w_auto_tick;

    logic        w_step_req;
    logic        r_step;
    logic [7:0]  r_bin;
    logic [7:0]  r_gray;

    // Two-flop synchronisers for the three asynchronous board inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_dir_s1  <= 1'b0;
            r_dir_s2  <= 1'b0;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_btn_s1  <= bus.button;
            r_btn_s2  <= r_btn_s1;
            r_dir_s1  <= bus.dir;
            r_dir_s2  <= r_dir_s1;
            r_auto_s1 <= bus.auto_en;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // Debounce state register; the press event is registered so it lands
    // exactly on the cycle the FSM enters HELD
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_db_cnt    <= '0;
            r_press_evt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_press_evt <= w_press;
        end
    end

    // Debounce next-state: stability counter restarts on every state change
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = '0;
        w_press      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_s2) w_state_nxt = ARM_PRESS;
            end
            ARM_PRESS: begin
                if (!r_btn_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    w_state_nxt = HELD;
                    w_press     = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 20'd1;
                end
            end
            HELD: begin
                if (!r_btn_s2) w_state_nxt = ARM_RELEASE;
            end
            ARM_RELEASE: begin
                if (r_btn_s2) begin
                    w_state_nxt = HELD;
                end else if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 20'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_auto_tick = r_auto_s2 && (r_auto_cnt == AUTO_PERIOD - 26'd1);
    assign w_step_req  = r_press_evt | w_auto_tick;

    // Free-running auto-step timer, parked at zero while auto mode is off
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_auto_cnt <= '0;
        end else if (!r_auto_s2 || w_auto_tick) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 26'd1;
        end
    end

    // Step strobe, up/down counter (8-bit wrap) and registered Gray encoding
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_step <= 1'b0;
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_step <= w_step_req;
            if (r_step) begin
                r_bin <= r_dir_s2 ? (r_bin + 8'd1) : (r_bin - 8'd1);
            end
            r_gray <= r_bin ^ (r_bin >> 1);
        end
    end

    assign bus.step_pulse = r_step;
    assign bus.bin_out    = r_bin;
    assign bus.gray_out   = r_gray;

endmodule

// File: tb/tb_gray_count_source.sv
// Bench for gray_count_source with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// Every cycle the DUT outputs are compared with a reference model that
// treats the debouncer as a run-length rule: the accepted level flips once
// the synchronised button has disagreed with it for DEBOUNCE_CYCLES+1
// consecutive cycles. Directed table vectors and corner sequences add
// constant expectations on top.
module tb_gray_count_source;

    localparam logic [19:0] DB_P   = 20'd4;
    localparam logic [25:0] AUTO_P = 26'd8;
    localparam int          DI     = 4;
    localparam int          PI     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_count_source_if bif();

    gray_count_source #(
        .DEBOUNCE_CYCLES(DB_P),
        .AUTO_PERIOD    (AUTO_P)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;
    int cyc_no   = 0;

    // Reference model state
    bit m_b1, m_b2, m_d1, m_d2, m_a1, m_a2;
    bit m_level;
    int m_run, m_acnt, m_bin, m_gray;
    bit m_evt, m_step;

    function automatic int gray_of(input int x);
        return (x ^ (x >> 1)) & 255;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_d1 = 0; m_d2 = 0; m_a1 = 0; m_a2 = 0;
        m_level = 0; m_run = 0; m_acnt = 0; m_bin = 0; m_gray = 0;
        m_evt = 0; m_step = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        int  run_n, acnt_n, bin_n, gray_n;
        bit  lvl_n, evt_n, tick, step_n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lvl_n = m_level;
        evt_n = 0;
        run_n = 0;
        if (m_b2 != m_level) begin
            run_n = m_run + 1;
            if (run_n == DI + 1) begin
                lvl_n = !m_level;
                run_n = 0;
                evt_n = lvl_n;
            end
        end
        tick   = m_a2 && (m_acnt == PI - 1);
        acnt_n = m_a2 ? (m_acnt + 1) % PI : 0;
        step_n = m_evt || tick;
        bin_n  = m_step ? (m_bin + (m_d2 ? 1 : 255)) % 256 : m_bin;
        gray_n = gray_of(m_bin);
        m_level = lvl_n; m_run = run_n; m_evt = evt_n;
        m_acnt = acnt_n; m_step = step_n; m_bin = bin_n; m_gray = gray_n;
        m_b2 = m_b1; m_b1 = bif.button;
        m_d2 = m_d1; m_d1 = bif.dir;
        m_a2 = m_a1; m_a1 = bif.auto_en;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_no++;
        check("bin_vs_model",  32'(bif.bin_out),    32'(m_bin));
        check("gray_vs_model", 32'(bif.gray_out),   32'(m_gray));
        check("step_vs_model", 32'(bif.step_pulse), 32'(m_step));
        if (bif.step_pulse === 1'b1) n_steps++;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bif.button  = 1'b0;
        bif.dir     = 1'b0;
        bif.auto_en = 1'b0;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic press(input int hold, input int rel);
        bif.button = 1'b1;
        repeat (hold) cyc();
        bif.button = 1'b0;
        repeat (rel) cyc();
    endtask

    typedef struct {
        bit         dir;
        int         hold;
        int         rel;
        logic [7:0] exp_bin;
        logic [7:0] exp_gray;
        int         exp_steps;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_seq[8];
    int         k, gi, last_step, len;
    logic [7:0] prev_gray;
    bit         found;

    initial begin
        bif.button  = 1'b0;
        bif.dir     = 1'b0;
        bif.auto_en = 1'b0;

        vecs[0] = '{1'b1, 20, 20, 8'h01, 8'h01, 1};
        vecs[1] = '{1'b1, 20, 20, 8'h02, 8'h03, 1};
        vecs[2] = '{1'b0, 20, 20, 8'h01, 8'h01, 1};
        vecs[3] = '{1'b0, 20, 20, 8'h00, 8'h00, 1};
        vecs[4] = '{1'b0, 20, 20, 8'hFF, 8'h80, 1};
        vecs[5] = '{1'b1, 20, 20, 8'h00, 8'h00, 1};
        vecs[6] = '{1'b1,  4, 20, 8'h00, 8'h00, 0};
        vecs[7] = '{1'b1,  5, 20, 8'h01, 8'h01, 1};
        vecs[8] = '{1'b0, 40, 20, 8'h00, 8'h00, 1};

        exp_seq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};

        // Reset and idle
        do_reset();
        n_steps = 0;
        repeat (20) cyc();
        check("idle_bin",   32'(bif.bin_out),  32'd0);
        check("idle_gray",  32'(bif.gray_out), 32'd0);
        check("idle_steps", 32'(n_steps),      32'd0);

        // Table-driven presses
        for (int i = 0; i < 9; i++) begin
            bif.dir = vecs[i].dir;
            n_steps = 0;
            press(vecs[i].hold, vecs[i].rel);
            check($sformatf("vec%0d_bin", i),   32'(bif.bin_out),  32'(vecs[i].exp_bin));
            check($sformatf("vec%0d_gray", i),  32'(bif.gray_out), 32'(vecs[i].exp_gray));
            check($sformatf("vec%0d_steps", i), 32'(n_steps),      32'(vecs[i].exp_steps));
        end

        // Press latency from bin=0
        bif.dir    = 1'b1;
        bif.button = 1'b1;
        k     = 0;
        found = 0;
        while (!found && k < 50) begin
            cyc();
            k++;
            if (bif.step_pulse === 1'b1) found = 1;
        end
        check("latency_step", found ? 32'(k) : 32'hFFFF_FFFF, 32'(DI + 4));
        check("latency_bin_hold", 32'(bif.bin_out), 32'd0);
        cyc();
        check("latency_bin_new",   32'(bif.bin_out),  32'd1);
        check("latency_gray_hold", 32'(bif.gray_out), 32'd0);
        cyc();
        check("latency_gray_new",  32'(bif.gray_out), 32'd1);
        bif.button = 1'b0;
        repeat (20) cyc();

        // Bounce then a clean press
        do_reset();
        bif.dir = 1'b1;
        n_steps = 0;
        for (int i = 0; i < 2; i++) begin
            bif.button = 1'b1; repeat (2) cyc();
            bif.button = 1'b0; repeat (2) cyc();
        end
        repeat (20) cyc();
        check("bounce_steps", 32'(n_steps),     32'd0);
        check("bounce_bin",   32'(bif.bin_out), 32'd0);
        press(20, 20);
        check("after_bounce_steps", 32'(n_steps),      32'd1);
        check("after_bounce_bin",   32'(bif.bin_out),  32'd1);
        check("after_bounce_gray",  32'(bif.gray_out), 32'd1);

        // Automatic stepping
        do_reset();
        bif.dir     = 1'b1;
        bif.auto_en = 1'b1;
        n_steps   = 0;
        prev_gray = 8'h00;
        gi        = 0;
        last_step = -1;
        for (int c = 0; c < 80; c++) begin
            cyc();
            if (bif.gray_out !== prev_gray) begin
                check("auto_gray_onebit", 32'($countones(bif.gray_out ^ prev_gray)), 32'd1);
                if (gi < 8) check($sformatf("auto_gray_seq%0d", gi), 32'(bif.gray_out), 32'(exp_seq[gi]));
                gi++;
                prev_gray = bif.gray_out;
            end
            if (bif.step_pulse === 1'b1) begin
                if (last_step >= 0) check("auto_step_interval", 32'(c - last_step), 32'd8);
                last_step = c;
            end
        end
        check("auto_step_count",   32'(n_steps), 32'd9);
        check("auto_gray_changes", 32'(gi),      32'd9);
        bif.auto_en = 1'b0;
        repeat (5) cyc();

        // Press event landing on the same cycle as an auto tick
        do_reset();
        bif.dir     = 1'b1;
        bif.auto_en = 1'b1;
        n_steps = 0;
        repeat (2) cyc();
        bif.button = 1'b1;
        repeat (10) cyc();
        bif.auto_en = 1'b0;
        repeat (10) cyc();
        bif.button = 1'b0;
        repeat (20) cyc();
        check("coincide_steps", 32'(n_steps),     32'd1);
        check("coincide_bin",   32'(bif.bin_out), 32'd1);

        // Reset asserted while the debouncer is arming a press
        do_reset();
        bif.dir = 1'b1;
        press(20, 20);
        check("pre_abort_bin", 32'(bif.bin_out), 32'd1);
        bif.button = 1'b1;
        repeat (4) cyc();
        #2;
        rst_n      = 1'b0;
        bif.button = 1'b0;
        model_reset();
        #1;
        check("abort_bin_now",  32'(bif.bin_out),    32'd0);
        check("abort_gray_now", 32'(bif.gray_out),   32'd0);
        check("abort_step_now", 32'(bif.step_pulse), 32'd0);
        repeat (2) cyc();
        rst_n   = 1'b1;
        n_steps = 0;
        repeat (20) cyc();
        check("abort_no_step", 32'(n_steps),     32'd0);
        check("abort_bin",     32'(bif.bin_out), 32'd0);

        // Randomised run against the model
        do_reset();
        for (int s = 0; s < 400; s++) begin
            bif.button = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) bif.dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bif.auto_en = !bif.auto_en;
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                model_reset();
                cyc();
                rst_n = 1'b1;
            end
            repeat (len) cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
